vga_mpu_bus_master: RTL
=======================

Name: vga_mpu_bus_master

Overview:
- Initiator for the 8-bit register/data bus served by the VGA block's MCU interface (chip select, write enable, 3-bit register select, bidirectional data, video interrupt).
- Converts single-beat requests from an on-chip requester (test sequencer, boot loader, soft CPU bridge) into timed bus cycles.
- Returns read data on a one-cycle response pulse.
- Lets logic on the same clock program video registers and VRAM through the same path an external MPU uses.

Parameters:
SETUP_CYCLES, 1, cycles register select/write enable/data are stable before chip select rises (1..15; 0 treated as 1)
STROBE_CYCLES, 2, cycles chip select is high (1..15; 0 treated as 1)
HOLD_CYCLES, 1, cycles select/enable/data are held after chip select falls (1..15; 0 treated as 1)
TURNAROUND_CYCLES, 1, idle cycles after a read before a new request is accepted (0..15)

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
requestValid  input  1  request present
requestReady  output  1  block can accept a request this cycle
requestWrite  input  1  1 = write cycle, 0 = read cycle
requestRegister  input  3  register select for the cycle
requestData  input  8  write data
requestWaitVBlank  input  1  hold the cycle until the next vblank interrupt; used only with the optional feature
responseValid  output  1  one-cycle pulse, read data valid
responseData  output  8  captured read data, holds until next read
busy  output  1  high whenever state is not IDLE
mpuChipSelect  output  1  active-high chip select
mpuWriteEnable  output  1  1 = write, 0 = read
mpuRegisterSelect  output  3  register select
mpuData  inout  8  data bus; driven only during write cycles, high-Z otherwise
mpuVideoInterrupt  input  1  video interrupt from the VGA block, same clock domain

Behaviour:
- Reset values: mpuChipSelect 0, mpuWriteEnable 0, mpuRegisterSelect 0, mpuData high-Z, responseValid 0, responseData 0x00, busy 0, requestReady 0.
- requestReady is 1 from the first cycle after reset deasserts.
- States: IDLE, WAIT_VBL (optional feature only), SETUP, STROBE, HOLD, TURN.
- 4-bit down-counter times SETUP, STROBE, HOLD and TURN.
- IDLE:
  - requestReady = 1.
  - On requestValid, latch requestWrite/requestRegister/requestData and go to SETUP (or WAIT_VBL, see optional feature).
  - requestReady drops the cycle after acceptance.
- SETUP:
  - mpuRegisterSelect and mpuWriteEnable drive the latched values; mpuChipSelect = 0.
  - For writes, mpuData drives the latched data.
  - Lasts SETUP_CYCLES, then STROBE.
- STROBE:
  - mpuChipSelect = 1; all other bus outputs held.
  - Lasts STROBE_CYCLES.
  - Reads sample mpuData into responseData on the last STROBE cycle's clock edge.
- HOLD:
  - mpuChipSelect = 0; select/enable/data held.
  - responseValid = 1 on the first HOLD cycle for reads only.
  - Lasts HOLD_CYCLES; writes then return to IDLE, reads go to TURN (or IDLE if TURNAROUND_CYCLES = 0).
- TURN: all outputs deasserted, mpuData high-Z, lasts TURNAROUND_CYCLES, then IDLE.
- On return to IDLE: mpuWriteEnable = 0, mpuData high-Z; mpuRegisterSelect keeps its last value.
- Latency, defaults, request accepted at edge T:
  - CS high cycles T+2..T+3.
  - Write: requestReady again at T+5.
  - Read: responseValid at T+4, requestReady again at T+6.
- Back-to-back requests: at most one request in flight; no queueing.
- Reset mid-cycle: next edge forces IDLE reset values; CS drops and the bus is released; no responseValid pulse.
- mpuVideoInterrupt is registered once; a rising edge is 0->1 between consecutive registered samples.

Optional Feature:
- Macro: VGA_MPU_VBLANK_WAIT_EN.
- Defined:
  - A request accepted with requestWaitVBlank = 1 enters WAIT_VBL.
  - In WAIT_VBL, all bus outputs are idle and busy = 1.
  - On the first detected interrupt rising edge after acceptance, go to SETUP the next cycle.
  - An edge in the acceptance cycle itself does not count.
  - A request with requestWaitVBlank = 0 goes straight to SETUP.
- Not defined: requestWaitVBlank is ignored, WAIT_VBL does not exist, and the interrupt register is removed.

Test Plan:
- Reset held 3 cycles mid-STROBE of a write -> CS 0 and mpuData high-Z the next cycle; requestReady 1 one cycle after reset drops; no response pulse.
- Write reg 3 data 0xA5 accepted at T (defaults) -> RS = 3, WE = 1, mpuData = 0xA5 from T+1 to T+4; CS = 1 only T+2..T+3; requestReady at T+5.
- Read reg 5, model drives 0x3C during STROBE -> responseValid single pulse at T+4; responseData = 0x3C held; mpuData never driven by the master; requestReady at T+6.
- requestValid held continuously with alternating write/read -> exactly one bus cycle per acceptance; no CS overlap; requestReady never high while busy.
- Parameters SETUP=3, STROBE=1, HOLD=2, TURNAROUND=0, read -> CS high exactly 1 cycle, 3 cycles after acceptance+1; requestReady 3 cycles after CS falls.
- With VGA_MPU_VBLANK_WAIT_EN, write with requestWaitVBlank=1, interrupt rises 20 cycles later -> no CS until the detected edge; SETUP begins the next cycle, followed by the normal write timing.

Source files
------------

// File: rtl/vga_mpu_bus_master.sv
// Purpose  : single-beat initiator for the VGA block's 8-bit MCU register/data bus.
// Latency  : accept at edge T; CS high T+SETUP+1 .. T+SETUP+STROBE; read data pulses on first HOLD cycle.
// Backpres.: requestReady is high only in IDLE; one request in flight, no queueing.
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   requestValid/requestReady    request handshake; requestWrite/Register/Data/WaitVBlank payload
//   responseValid/responseData   one-cycle read pulse; data held until the next read completes
//   busy                         high whenever the sequencer is not idle
//   mpuChipSelect/WriteEnable/RegisterSelect/Data  bus pins (data driven only during writes)
//   mpuVideoInterrupt            video interrupt, same clock domain
// Optional feature macro: VGA_MPU_VBLANK_WAIT_EN (hold requests flagged requestWaitVBlank
// until the next interrupt rising edge).
module vga_mpu_bus_master #(
    parameter int SETUP_CYCLES      = 1,
    parameter int STROBE_CYCLES     = 2,
    parameter int HOLD_CYCLES       = 1,
    parameter int TURNAROUND_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       requestValid,
    output logic       requestReady,
    input  logic       requestWrite,
    input  logic [2:0] requestRegister,
    input  logic [7:0] requestData,
    input  logic       requestWaitVBlank,
    output logic       responseValid,
    output logic [7:0] responseData,
    output logic       busy,
    output logic       mpuChipSelect,
    output logic       mpuWriteEnable,
    output logic [2:0] mpuRegisterSelect,
    inout  wire  [7:0] mpuData,
    input  logic       mpuVideoInterrupt
);

    // Phase lengths clamped into the 4-bit counter range; zero means one cycle
    // except for turnaround, where zero skips the phase entirely.
    localparam logic [3:0] SETUP_LEN  = (SETUP_CYCLES  < 1) ? 4'd1 : (SETUP_CYCLES  > 15) ? 4'd15 : 4'(SETUP_CYCLES);
    localparam logic [3:0] STROBE_LEN = (STROBE_CYCLES < 1) ? 4'd1 : (STROBE_CYCLES > 15) ? 4'd15 : 4'(STROBE_CYCLES);
    localparam logic [3:0] HOLD_LEN   = (HOLD_CYCLES   < 1) ? 4'd1 : (HOLD_CYCLES   > 15) ? 4'd15 : 4'(HOLD_CYCLES);
    localparam logic [3:0] TURN_LEN   = (TURNAROUND_CYCLES < 0) ? 4'd0 :
                                        (TURNAROUND_CYCLES > 15) ? 4'd15 : 4'(TURNAROUND_CYCLES);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_VBL = 3'd1;
    localparam logic [2:0] SETUP    = 3'd2;
    localparam logic [2:0] STROBE   = 3'd3;
    localparam logic [2:0] HOLD     = 3'd4;
    localparam logic [2:0] TURN     = 3'd5;

    logic [2:0] state;
    logic [3:0] count;
    logic       latWrite;
    logic [2:0] latRegister;
    logic [7:0] latData;
    logic       outOfReset;   // keeps requestReady low in the cycle reset is still asserted
    logic       busCycle;
    logic       startWait;
    logic       irqRise;

`ifdef VGA_MPU_VBLANK_WAIT_EN
    logic irqSample;
    logic irqPrev;

    assign irqRise   = irqSample & ~irqPrev;
    assign startWait = requestWaitVBlank;

    always_ff @(posedge clock) begin
        if (reset) begin
            irqSample <= 1'b0;
            irqPrev   <= 1'b0;
        end else begin
            irqSample <= mpuVideoInterrupt;
            irqPrev   <= irqSample;
        end
    end
`else
    logic unusedInputs;

    assign unusedInputs = requestWaitVBlank ^ mpuVideoInterrupt;
    assign irqRise      = 1'b0;
    assign startWait    = 1'b0;
`endif

    assign busCycle          = (state == SETUP) || (state == STROBE) || (state == HOLD);
    assign requestReady      = outOfReset && (state == IDLE);
    assign busy              = (state != IDLE);
    assign mpuChipSelect     = (state == STROBE);
    assign mpuWriteEnable    = latWrite && busCycle;
    assign mpuRegisterSelect = latRegister;
    assign mpuData           = (latWrite && busCycle) ? latData : 8'hzz;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            count         <= 4'd0;
            latWrite      <= 1'b0;
            latRegister   <= 3'd0;
            latData       <= 8'h00;
            responseValid <= 1'b0;
            responseData  <= 8'h00;
            outOfReset    <= 1'b0;
        end else begin
            outOfReset    <= 1'b1;
            responseValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (requestValid && outOfReset) begin
                        latWrite    <= requestWrite;
                        latRegister <= requestRegister;
                        latData     <= requestData;
                        count       <= SETUP_LEN - 4'd1;
                        state       <= startWait ? WAIT_VBL : SETUP;
                    end
                end
                WAIT_VBL: begin
                    // Only edges seen while waiting count; the acceptance cycle is IDLE.
                    if (irqRise) begin
                        state <= SETUP;
                        count <= SETUP_LEN - 4'd1;
                    end
                end
                SETUP: begin
                    if (count == 4'd0) begin
                        state <= STROBE;
                        count <= STROBE_LEN - 4'd1;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                STROBE: begin
                    if (count == 4'd0) begin
                        state <= HOLD;
                        count <= HOLD_LEN - 4'd1;
                        if (!latWrite) begin
                            responseData  <= mpuData;
                            responseValid <= 1'b1;
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                HOLD: begin
                    if (count == 4'd0) begin
                        if (!latWrite && (TURN_LEN != 4'd0)) begin
                            state <= TURN;
                            count <= TURN_LEN - 4'd1;
                        end else begin
                            state    <= IDLE;
                            latWrite <= 1'b0;
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                TURN: begin
                    if (count == 4'd0) begin
                        state    <= IDLE;
                        latWrite <= 1'b0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
